// File: rtl/fft16_pkg.sv
// Shared constants, complex word type, PCM conversion and feeder state encoding
// for the 16-point FFT frame feeder.
package fft16_pkg;

  localparam int N_POINT  = 16;
  localparam int SAMPLE_W = 16;
  localparam int FRAC_W   = 16;
  localparam int CPLX_W   = 64;
  localparam int CNT_W    = 5;

  typedef struct packed {
    logic signed [31:0] re;
    logic signed [31:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } feed_state_t;

  // Sign-extend the sample into the integer part of Q16.16; imaginary part is zero.
  function automatic cplx_t pcm_to_cplx(input logic signed [SAMPLE_W-1:0] s);
    cplx_t              c;
    logic signed [31:0] ext;
    ext  = 32'(s);
    c.re = ext <<< FRAC_W;
    c.im = '0;
    return c;
  endfunction

endpackage

// File: rtl/fft16_frame_feeder_bank.sv
// One 16-entry bank of packed complex words: single write port, whole bank
// visible on a flat read bus (word k at [CPLX_W*k +: CPLX_W]).
module fft16_sample_bank
  import fft16_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_we,
  input  logic [3:0]                i_addr,
  input  logic [CPLX_W-1:0]         i_data,
  output logic [N_POINT*CPLX_W-1:0] o_rd
);

  logic [CPLX_W-1:0] r_mem [N_POINT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_POINT; k++) r_mem[k] <= '0;
    end else if (i_we) begin
      r_mem[i_addr] <= i_data;
    end
  end

  for (genvar k = 0; k < N_POINT; k++) begin : g_rd
    assign o_rd[k*CPLX_W +: CPLX_W] = r_mem[k];
  end

endmodule

// File: rtl/fft16_frame_feeder.sv
// Ping-pong frame feeder in front of the 16-point FFT. Optional macro
// FFT16_FEED_DROP_EN: never backpressure, discard samples in STALL and count them.
//
// state   | meaning
// S_FILL  | fill bank filling, no frame in flight
// S_RUN   | frame in flight, fill bank accepting
// S_STALL | fill bank full while a frame is in flight
module fft16_frame_feeder
  import fft16_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SAMPLE_W-1:0]       i_sample,
  input  logic                      i_sample_valid,
  output logic                      o_sample_ready,
  output logic [N_POINT*CPLX_W-1:0] o_frame,
  output logic                      o_start,
  input  logic                      i_fft_done,
  output logic                      o_busy
`ifdef FFT16_FEED_DROP_EN
  ,
  output logic [7:0]                o_drop_cnt
`endif
);

  feed_state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]           r_wr_cnt;
  logic                       r_fill_sel;
  logic                       r_start;
  logic                       w_busy, w_cnt_full, w_wr, w_full, w_launch, w_done;
  cplx_t                      w_wdata;
  logic [N_POINT*CPLX_W-1:0]  w_rd_a, w_rd_b;

  assign w_busy     = (r_state != S_FILL);
  assign w_cnt_full = (r_wr_cnt == CNT_W'(N_POINT));

`ifdef FFT16_FEED_DROP_EN
  assign o_sample_ready = 1'b1;
`else
  assign o_sample_ready = !(w_cnt_full && w_busy);
`endif

  assign w_wr     = i_sample_valid && o_sample_ready && !w_cnt_full;
  assign w_full   = w_cnt_full || (w_wr && (r_wr_cnt == CNT_W'(N_POINT-1)));
  assign w_done   = i_fft_done && w_busy;
  // A completing frame may launch on the same edge the FFT reports done.
  assign w_launch = w_full && (!w_busy || i_fft_done);
  assign w_wdata  = pcm_to_cplx(i_sample);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL:  if (w_launch) w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_launch)    w_state_nxt = S_RUN;
        else if (w_full) w_state_nxt = S_STALL;
        else if (w_done) w_state_nxt = S_FILL;
      end
      S_STALL: if (w_done) w_state_nxt = S_RUN;
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FILL;
      r_wr_cnt   <= '0;
      r_fill_sel <= 1'b0;
      r_start    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_start <= w_launch;
      if (w_launch) begin
        r_fill_sel <= ~r_fill_sel;
        r_wr_cnt   <= '0;
      end else if (w_wr) begin
        r_wr_cnt <= r_wr_cnt + CNT_W'(1);
      end
    end
  end

`ifdef FFT16_FEED_DROP_EN
  logic [7:0] r_drop_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_drop_cnt <= '0;
    else if (i_sample_valid && (r_state == S_STALL) && (r_drop_cnt != 8'hFF))
      r_drop_cnt <= r_drop_cnt + 8'd1;
  end
  assign o_drop_cnt = r_drop_cnt;
`endif

  fft16_sample_bank u_bank_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_we   (w_wr && !r_fill_sel),
    .i_addr (r_wr_cnt[3:0]),
    .i_data (w_wdata),
    .o_rd   (w_rd_a)
  );

  fft16_sample_bank u_bank_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_we   (w_wr && r_fill_sel),
    .i_addr (r_wr_cnt[3:0]),
    .i_data (w_wdata),
    .o_rd   (w_rd_b)
  );

  // The presented bank is always the one not being filled.
  assign o_frame = r_fill_sel ? w_rd_a : w_rd_b;
  assign o_start = r_start;
  assign o_busy  = w_busy;

endmodule

// File: tb/tb_fft16_frame_feeder.sv
// Self-checking bench for fft16_frame_feeder: frame scoreboard, conversion
// table, and directed sequences for stall, coincident done, reset and drop mode.
module tb_fft16_frame_feeder;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   i_sample = '0;
  logic          i_sample_valid = 1'b0;
  logic          o_sample_ready;
  logic [1023:0] o_frame;
  logic          o_start;
  logic          i_fft_done = 1'b0;
  logic          o_busy;
`ifdef FFT16_FEED_DROP_EN
  logic [7:0]    o_drop_cnt;
`endif

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b1;

  fft16_frame_feeder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_sample       (i_sample),
    .i_sample_valid (i_sample_valid),
    .o_sample_ready (o_sample_ready),
    .o_frame        (o_frame),
    .o_start        (o_start),
    .i_fft_done     (i_fft_done),
    .o_busy         (o_busy)
`ifdef FFT16_FEED_DROP_EN
    ,
    .o_drop_cnt     (o_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_frame(input string nm, input logic [1023:0] exp);
    int first_bad;
    first_bad = -1;
    for (int k = 15; k >= 0; k--)
      if (o_frame[64*k +: 64] !== exp[64*k +: 64]) first_bad = k;
    total++;
    if (first_bad >= 0) begin
      bad++;
      $display("FAIL %s: word%0d got %h want %h", nm, first_bad,
               o_frame[64*first_bad +: 64], exp[64*first_bad +: 64]);
    end
  endtask

  // Scoreboard: accepted samples assemble expected frames; each o_start pops one.
  logic [15:0]   acc[$];
  logic [1023:0] exp_q[$];
  logic [1023:0] last_frame = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc.delete();
      exp_q.delete();
    end else if (mon_en && i_sample_valid && o_sample_ready) begin
      acc.push_back(i_sample);
      if (acc.size() == 16) begin
        logic [1023:0] f;
        for (int k = 0; k < 16; k++) f[64*k +: 64] = {acc[k], 48'h0};
        exp_q.push_back(f);
        acc.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (o_start) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_start: got o_start=1 want no frame pending");
        end else begin
          last_frame = exp_q.pop_front();
          chk_frame("sb_frame", last_frame);
        end
      end else if (o_busy) begin
        chk_frame("hold_frame", last_frame);
      end
    end
  end

  task automatic send(input logic [15:0] s);
    bit ok;
    ok = 1'b0;
    i_sample       = s;
    i_sample_valid = 1'b1;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (o_sample_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    i_sample_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got ready=0 for 300 cycles want ready=1");
    end
  endtask

  task automatic pulse_done();
    i_fft_done = 1'b1;
    @(posedge clk);
    #1;
    i_fft_done = 1'b0;
  endtask

  typedef struct {
    logic [15:0] s;
    logic [63:0] w;
  } vec_t;
  vec_t tbl[16];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{16'h8000, 64'h80000000_00000000};
    tbl[1]  = '{16'h7FFF, 64'h7FFF0000_00000000};
    tbl[2]  = '{16'hFFFF, 64'hFFFF0000_00000000};
    tbl[3]  = '{16'h0000, 64'h00000000_00000000};
    tbl[4]  = '{16'h0001, 64'h00010000_00000000};
    tbl[5]  = '{16'h1234, 64'h12340000_00000000};
    tbl[6]  = '{16'hABCD, 64'hABCD0000_00000000};
    tbl[7]  = '{16'h00FF, 64'h00FF0000_00000000};
    tbl[8]  = '{16'hFF00, 64'hFF000000_00000000};
    tbl[9]  = '{16'h5555, 64'h55550000_00000000};
    tbl[10] = '{16'hAAAA, 64'hAAAA0000_00000000};
    tbl[11] = '{16'h0F0F, 64'h0F0F0000_00000000};
    tbl[12] = '{16'hF0F0, 64'hF0F00000_00000000};
    tbl[13] = '{16'h7000, 64'h70000000_00000000};
    tbl[14] = '{16'h8001, 64'h80010000_00000000};
    tbl[15] = '{16'h4000, 64'h40000000_00000000};

    // Reset values
    #12;
    chk("rst_ready", 64'(o_sample_ready), 64'd1);
    chk("rst_start", 64'(o_start), 64'd0);
    chk("rst_busy",  64'(o_busy), 64'd0);
    chk("rst_frame_w0", o_frame[63:0], 64'd0);
`ifdef FFT16_FEED_DROP_EN
    chk("rst_drop", 64'(o_drop_cnt), 64'd0);
`endif
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Samples 1..16 back to back with the FFT idle
    for (int k = 1; k <= 15; k++) send(16'(k));
    chk("pre16_start", 64'(o_start), 64'd0);
    send(16'd16);
    chk("lat_start", 64'(o_start), 64'd1);
    chk("lat_busy",  64'(o_busy), 64'd1);
    chk("t2_word0",  o_frame[63:0], 64'h00010000_00000000);
    chk("t2_word15", o_frame[1023:960], 64'h00100000_00000000);
    @(posedge clk);
    #1;
    chk("single_start", 64'(o_start), 64'd0);
    pulse_done();
    chk("done_busy", 64'(o_busy), 64'd0);
    pulse_done();
    chk("idle_done_busy",  64'(o_busy), 64'd0);
    chk("idle_done_start", 64'(o_start), 64'd0);

    // Conversion table as one frame
    for (int k = 0; k < 16; k++) send(tbl[k].s);
    chk("tbl_start", 64'(o_start), 64'd1);
    for (int k = 0; k < 16; k++) chk($sformatf("tbl_word%0d", k), o_frame[64*k +: 64], tbl[k].w);
    pulse_done();

    // Done withheld: two frames accepted, then stall
    for (int k = 0; k < 32; k++) send(16'(300 + k));
    chk("stall_ready", 64'(o_sample_ready), 64'd0);
    chk("stall_busy",  64'(o_busy), 64'd1);
    i_sample       = 16'd332;
    i_sample_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("stall_ready_hold", 64'(o_sample_ready), 64'd0);
    chk("stall_word0", o_frame[63:0], {16'd300, 48'h0});
    pulse_done();
    chk("relaunch_start", 64'(o_start), 64'd1);
    chk("relaunch_ready", 64'(o_sample_ready), 64'd1);
    chk("relaunch_word0", o_frame[63:0], {16'd316, 48'h0});
    for (int k = 32; k < 48; k++) send(16'(300 + k));
    chk("stall2_ready", 64'(o_sample_ready), 64'd0);

    // Done coincident with the 16th sample of the next frame
    pulse_done();
    chk("t4_pre_start", 64'(o_start), 64'd1);
    for (int k = 0; k < 15; k++) send(16'(500 + k));
    chk("t4_pre_busy", 64'(o_busy), 64'd1);
    i_fft_done = 1'b1;
    send(16'd515);
    i_fft_done = 1'b0;
    chk("t4_start", 64'(o_start), 64'd1);
    chk("t4_busy",  64'(o_busy), 64'd1);
    chk("t4_word0", o_frame[63:0], {16'd500, 48'h0});
    pulse_done();
    chk("t4_end_busy", 64'(o_busy), 64'd0);

    // Asynchronous reset mid-frame, then a fresh frame
    for (int k = 0; k < 7; k++) send(16'(1000 + k));
    i_sample_valid = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_ready", 64'(o_sample_ready), 64'd1);
    chk("arst_start", 64'(o_start), 64'd0);
    chk("arst_busy",  64'(o_busy), 64'd0);
    chk("arst_frame_w0",  o_frame[63:0], 64'd0);
    chk("arst_frame_w15", o_frame[1023:960], 64'd0);
    i_sample_valid = 1'b0;
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 16; k++) send(16'(100 + k));
    chk("t5_start",  64'(o_start), 64'd1);
    chk("t5_word0",  o_frame[63:0], 64'h00640000_00000000);
    chk("t5_word15", o_frame[1023:960], 64'h00730000_00000000);
    pulse_done();

`ifdef FFT16_FEED_DROP_EN
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 32; k++) send(16'(200 + k));
    chk("drop_ready", 64'(o_sample_ready), 64'd1);
    i_sample       = 16'hDEAD;
    i_sample_valid = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    i_sample_valid = 1'b0;
    chk("drop_cnt",    64'(o_drop_cnt), 64'd255);
    chk("drop_busy",   64'(o_busy), 64'd1);
    chk("drop_word0",  o_frame[63:0], 64'h00C80000_00000000);
    chk("drop_word15", o_frame[1023:960], 64'h00D70000_00000000);
    pulse_done();
    chk("drop_relaunch", 64'(o_start), 64'd1);
    chk("drop_frame2_w0", o_frame[63:0], 64'h00D80000_00000000);
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
